fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline: PC register, direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and the IF/ID pipeline latch.
- Consumes the hazard unit's pcen, if_id_en and if_id_flush, plus MEM-stage branch resolution.
- Produces the instruction memory request and the IF/ID latch contents consumed by decode.

---
 rtl/fetch_stage.sv | 211 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
// -----------
// Instruction-fetch stage of the 5-stage pipeline. It holds the PC register,
// a direct-mapped branch target buffer (BTB) with 2-bit saturating counters,
// and the IF/ID pipeline latch that feeds decode.
//
// Ports:
//   CLK, RST            clock (rising edge) and synchronous active-high reset
//   ihit, imemload      instruction memory handshake and returned instruction
//   imemaddr, imemREN   fetch address (always the PC) and read enable
//   pcen                hazard unit: PC may advance
//   if_id_en            hazard unit: IF/ID latch may capture
//   if_id_flush         hazard unit: clear IF/ID latch
//   halt                halt instruction committed downstream
//   mem_redirect        MEM stage misprediction, refetch from mem_target
//   mem_target          correct next PC supplied by MEM
//   upd_valid           MEM stage resolved a branch; train the BTB
//   upd_pc, upd_target  resolved branch PC and its taken target
//   upd_taken           resolved branch outcome
//   if_id_*             IF/ID latch contents presented to decode
module fetch_stage #(
    parameter logic [31:0] PC_INIT     = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic [31:0] imemaddr,
    output logic        imemREN,
    input  logic        pcen,
    input  logic        if_id_en,
    input  logic        if_id_flush,
    input  logic        halt,
    input  logic        mem_redirect,
    input  logic [31:0] mem_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_npc,
    output logic        if_id_pred_taken,
    output logic [31:0] if_id_pred_target,
    output logic        if_id_valid
);

    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDXW;

    // Architectural state
    logic [31:0]      pc_q, pc_d;
    logic             halted_q, halted_d;

    logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic [TAGW-1:0]  btb_tag_q    [BTB_ENTRIES];
    logic [TAGW-1:0]  btb_tag_d    [BTB_ENTRIES];
    logic [31:0]      btb_target_q [BTB_ENTRIES];
    logic [31:0]      btb_target_d [BTB_ENTRIES];
    logic [1:0]       btb_cnt_q    [BTB_ENTRIES];
    logic [1:0]       btb_cnt_d    [BTB_ENTRIES];

    logic [31:0]      if_id_instr_q, if_id_instr_d;
    logic [31:0]      if_id_pc_q, if_id_pc_d;
    logic [31:0]      if_id_npc_q, if_id_npc_d;
    logic             if_id_pred_taken_q, if_id_pred_taken_d;
    logic [31:0]      if_id_pred_target_q, if_id_pred_target_d;
    logic             if_id_valid_q, if_id_valid_d;

    // Lookup-side signals
    logic [IDXW-1:0]  idx;
    logic [TAGW-1:0]  tag;
    logic [31:0]      pc_plus4;
    logic             btb_hit;
    logic             pred_taken;
    logic [31:0]      pred_target;

    // Update-side signals
    logic [IDXW-1:0]  u_idx;
    logic [TAGW-1:0]  u_tag;
    logic             u_hit;

    // The low two bits of the branch PC carry no information (word aligned)
    logic             upd_pc_unused;
    assign upd_pc_unused = ^upd_pc[1:0];

    assign imemaddr          = pc_q;
    assign imemREN           = ~halted_q;
    assign if_id_instr       = if_id_instr_q;
    assign if_id_pc          = if_id_pc_q;
    assign if_id_npc         = if_id_npc_q;
    assign if_id_pred_taken  = if_id_pred_taken_q;
    assign if_id_pred_target = if_id_pred_target_q;
    assign if_id_valid       = if_id_valid_q;

    // BTB lookup reads the registered table, so an update landing on the
    // same index this cycle is only visible from the next cycle onward.
    always_comb begin
        idx         = pc_q[IDXW+1:2];
        tag         = pc_q[31:IDXW+2];
        pc_plus4    = pc_q + 32'd4;
        btb_hit     = btb_valid_q[idx] && (btb_tag_q[idx] == tag);
        pred_taken  = btb_hit && btb_cnt_q[idx][1];
        pred_target = pred_taken ? btb_target_q[idx] : pc_plus4;
    end

    // Next PC and halt. A halt arriving together with a redirect drops the
    // redirect; once halted the PC is frozen until reset.
    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q | halt;
        if (halted_q) begin
            pc_d = pc_q;
        end else if (mem_redirect && !halt) begin
            pc_d = mem_target;
        end else if (pcen) begin
            pc_d = pred_target;
        end
    end

    // IF/ID latch: flush beats enable; valid reflects whether memory
    // actually returned data in the capture cycle.
    always_comb begin
        if_id_instr_d       = if_id_instr_q;
        if_id_pc_d          = if_id_pc_q;
        if_id_npc_d         = if_id_npc_q;
        if_id_pred_taken_d  = if_id_pred_taken_q;
        if_id_pred_target_d = if_id_pred_target_q;
        if_id_valid_d       = if_id_valid_q;
        if (if_id_flush) begin
            if_id_instr_d       = 32'd0;
            if_id_pc_d          = 32'd0;
            if_id_npc_d         = 32'd0;
            if_id_pred_taken_d  = 1'b0;
            if_id_pred_target_d = 32'd0;
            if_id_valid_d       = 1'b0;
        end else if (if_id_en) begin
            if_id_instr_d       = imemload;
            if_id_pc_d          = pc_q;
            if_id_npc_d         = pc_plus4;
            if_id_pred_taken_d  = pred_taken;
            if_id_pred_target_d = pred_target;
            if_id_valid_d       = ihit;
        end
    end

    // BTB training. A hit nudges the counter (saturating both ways) and
    // refreshes the target only on taken outcomes; a taken miss evicts
    // whatever lived at that index and starts it weakly taken.
    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        btb_cnt_d    = btb_cnt_q;
        u_idx        = upd_pc[IDXW+1:2];
        u_tag        = upd_pc[31:IDXW+2];
        u_hit        = btb_valid_q[u_idx] && (btb_tag_q[u_idx] == u_tag);
        if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    btb_target_d[u_idx] = upd_target;
                    if (btb_cnt_q[u_idx] != 2'b11) begin
                        btb_cnt_d[u_idx] = btb_cnt_q[u_idx] + 2'd1;
                    end
                end else if (btb_cnt_q[u_idx] != 2'b00) begin
                    btb_cnt_d[u_idx] = btb_cnt_q[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                btb_valid_d[u_idx]  = 1'b1;
                btb_tag_d[u_idx]    = u_tag;
                btb_target_d[u_idx] = upd_target;
                btb_cnt_d[u_idx]    = 2'b10;
            end
        end
    end

    // State registers; reset overrides any redirect or BTB update in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q                <= PC_INIT;
            halted_q            <= 1'b0;
            btb_valid_q         <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= 32'd0;
                btb_cnt_q[i]    <= 2'b01;
            end
            if_id_instr_q       <= 32'd0;
            if_id_pc_q          <= 32'd0;
            if_id_npc_q         <= 32'd0;
            if_id_pred_taken_q  <= 1'b0;
            if_id_pred_target_q <= 32'd0;
            if_id_valid_q       <= 1'b0;
        end else begin
            pc_q                <= pc_d;
            halted_q            <= halted_d;
            btb_valid_q         <= btb_valid_d;
            btb_tag_q           <= btb_tag_d;
            btb_target_q        <= btb_target_d;
            btb_cnt_q           <= btb_cnt_d;
            if_id_instr_q       <= if_id_instr_d;
            if_id_pc_q          <= if_id_pc_d;
            if_id_npc_q         <= if_id_npc_d;
            if_id_pred_taken_q  <= if_id_pred_taken_d;
            if_id_pred_target_q <= if_id_pred_target_d;
            if_id_valid_q       <= if_id_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// --------------
// Directed bench for fetch_stage (PC_INIT = 0, 16 BTB entries). A reference
// model of the fetch stage runs alongside the DUT and every output is checked
// against it each cycle; directed steps also check hand-computed values.
module tb_fetch_stage;

    localparam int NENT = 16;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic [31:0] imemaddr;
    logic        imemREN;
    logic        pcen;
    logic        if_id_en;
    logic        if_id_flush;
    logic        halt;
    logic        mem_redirect;
    logic [31:0] mem_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_npc;
    logic        if_id_pred_taken;
    logic [31:0] if_id_pred_target;
    logic        if_id_valid;

    int numChecks = 0;
    int numFails  = 0;

    fetch_stage #(
        .PC_INIT     (32'h0000_0000),
        .BTB_ENTRIES (NENT)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .ihit              (ihit),
        .imemload          (imemload),
        .imemaddr          (imemaddr),
        .imemREN           (imemREN),
        .pcen              (pcen),
        .if_id_en          (if_id_en),
        .if_id_flush       (if_id_flush),
        .halt              (halt),
        .mem_redirect      (mem_redirect),
        .mem_target        (mem_target),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_target        (upd_target),
        .upd_taken         (upd_taken),
        .if_id_instr       (if_id_instr),
        .if_id_pc          (if_id_pc),
        .if_id_npc         (if_id_npc),
        .if_id_pred_taken  (if_id_pred_taken),
        .if_id_pred_target (if_id_pred_target),
        .if_id_valid       (if_id_valid)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model state
    bit          mKnown = 0;
    logic [31:0] mPc;
    bit          mHalted;
    bit          mValid  [NENT];
    int unsigned mTag    [NENT];
    logic [31:0] mTarget [NENT];
    int          mCnt    [NENT];
    logic [31:0] mInstr, mIdPc, mNpc, mPredTarget;
    bit          mPredTaken, mIdValid;

    // Model: one step per rising edge, reading only bench-driven inputs
    always @(posedge CLK) begin
        int unsigned li, ui;
        bit          lhit, lpt, uhit;
        logic [31:0] lnext;
        if (RST) begin
            mKnown = 1;
            mPc = 32'h0; mHalted = 0;
            for (int i = 0; i < NENT; i++) begin
                mValid[i] = 0; mTag[i] = 0; mTarget[i] = 0; mCnt[i] = 1;
            end
            mInstr = 0; mIdPc = 0; mNpc = 0; mPredTarget = 0;
            mPredTaken = 0; mIdValid = 0;
        end else begin
            li    = (mPc / 4) % NENT;
            lhit  = mValid[li] && (mTag[li] == mPc / (4 * NENT));
            lpt   = lhit && (mCnt[li] >= 2);
            lnext = lpt ? mTarget[li] : mPc + 32'd4;
            if (if_id_flush) begin
                mInstr = 0; mIdPc = 0; mNpc = 0; mPredTarget = 0;
                mPredTaken = 0; mIdValid = 0;
            end else if (if_id_en) begin
                mInstr = imemload; mIdPc = mPc; mNpc = mPc + 32'd4;
                mPredTaken = lpt; mPredTarget = lnext; mIdValid = ihit;
            end
            if (!mHalted) begin
                if (mem_redirect && !halt) mPc = mem_target;
                else if (pcen) mPc = lnext;
            end
            if (halt) mHalted = 1;
            if (upd_valid) begin
                ui   = (upd_pc / 4) % NENT;
                uhit = mValid[ui] && (mTag[ui] == upd_pc / (4 * NENT));
                if (uhit) begin
                    if (upd_taken) begin
                        mCnt[ui] = (mCnt[ui] < 3) ? mCnt[ui] + 1 : 3;
                        mTarget[ui] = upd_target;
                    end else begin
                        mCnt[ui] = (mCnt[ui] > 0) ? mCnt[ui] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    mValid[ui] = 1; mTag[ui] = upd_pc / (4 * NENT);
                    mTarget[ui] = upd_target; mCnt[ui] = 2;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge CLK) begin
        if (mKnown) begin
            checkOutput("m.imemaddr", imemaddr, mPc);
            checkOutput("m.imemREN", {31'd0, imemREN}, {31'd0, ~mHalted});
            checkOutput("m.if_id_instr", if_id_instr, mInstr);
            checkOutput("m.if_id_pc", if_id_pc, mIdPc);
            checkOutput("m.if_id_npc", if_id_npc, mNpc);
            checkOutput("m.if_id_pred_taken", {31'd0, if_id_pred_taken}, {31'd0, mPredTaken});
            checkOutput("m.if_id_pred_target", if_id_pred_target, mPredTarget);
            checkOutput("m.if_id_valid", {31'd0, if_id_valid}, {31'd0, mIdValid});
        end
    end

    task automatic clearInputs();
        ihit = 0; imemload = 0; pcen = 0; if_id_en = 0; if_id_flush = 0;
        halt = 0; mem_redirect = 0; mem_target = 0;
        upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
    endtask

    // Hold the currently driven inputs across n rising edges
    task automatic applyStimulus(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic updateBtb(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        clearInputs();
        upd_valid = 1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
        applyStimulus(1);
        clearInputs();
    endtask

    // Redirect to pc, then fetch it once with the latch capturing
    task automatic fetchAt(input logic [31:0] pc);
        clearInputs();
        mem_redirect = 1; mem_target = pc;
        applyStimulus(1);
        clearInputs();
        pcen = 1; if_id_en = 1; ihit = 1; imemload = 32'hAA;
        applyStimulus(1);
        clearInputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearInputs();
        RST = 1;
        applyStimulus(2);
        RST = 0;
        checkOutput("rst.imemaddr", imemaddr, 32'h0);
        checkOutput("rst.imemREN", {31'd0, imemREN}, 32'd1);
        checkOutput("rst.if_id_valid", {31'd0, if_id_valid}, 32'd0);
        checkOutput("rst.if_id_pc", if_id_pc, 32'h0);

        // Sequential fetch
        pcen = 1; if_id_en = 1; ihit = 1;
        imemload = 32'h11; applyStimulus(1);
        checkOutput("seq0.imemaddr", imemaddr, 32'h4);
        checkOutput("seq0.if_id_pc", if_id_pc, 32'h0);
        checkOutput("seq0.if_id_npc", if_id_npc, 32'h4);
        checkOutput("seq0.if_id_instr", if_id_instr, 32'h11);
        checkOutput("seq0.if_id_valid", {31'd0, if_id_valid}, 32'd1);
        checkOutput("seq0.pred_taken", {31'd0, if_id_pred_taken}, 32'd0);
        imemload = 32'h22; applyStimulus(1);
        checkOutput("seq1.imemaddr", imemaddr, 32'h8);
        checkOutput("seq1.if_id_pc", if_id_pc, 32'h4);
        checkOutput("seq1.if_id_npc", if_id_npc, 32'h8);
        imemload = 32'h33; applyStimulus(1);
        checkOutput("seq2.imemaddr", imemaddr, 32'hC);
        checkOutput("seq2.if_id_pc", if_id_pc, 32'h8);
        checkOutput("seq2.if_id_npc", if_id_npc, 32'hC);
        checkOutput("seq2.pred_target", if_id_pred_target, 32'hC);

        // Stall then flush
        pcen = 0; if_id_en = 0; imemload = 32'h44;
        applyStimulus(2);
        checkOutput("stall.imemaddr", imemaddr, 32'hC);
        checkOutput("stall.if_id_instr", if_id_instr, 32'h33);
        checkOutput("stall.if_id_pc", if_id_pc, 32'h8);
        if_id_flush = 1; if_id_en = 1;
        applyStimulus(1);
        clearInputs();
        checkOutput("flush.if_id_instr", if_id_instr, 32'h0);
        checkOutput("flush.if_id_npc", if_id_npc, 32'h0);
        checkOutput("flush.if_id_valid", {31'd0, if_id_valid}, 32'd0);
        checkOutput("flush.imemaddr", imemaddr, 32'hC);

        // Allocate a taken branch at 0x10
        updateBtb(32'h10, 32'h40, 1);
        fetchAt(32'h10);
        checkOutput("alloc.imemaddr", imemaddr, 32'h40);
        checkOutput("alloc.if_id_pc", if_id_pc, 32'h10);
        checkOutput("alloc.pred_taken", {31'd0, if_id_pred_taken}, 32'd1);
        checkOutput("alloc.pred_target", if_id_pred_target, 32'h40);
        checkOutput("alloc.if_id_npc", if_id_npc, 32'h14);

        // Saturate high, then one not-taken must still predict taken
        repeat (3) updateBtb(32'h10, 32'h40, 1);
        updateBtb(32'h10, 32'h990, 0);
        fetchAt(32'h10);
        checkOutput("sat3nt1.imemaddr", imemaddr, 32'h40);
        checkOutput("sat3nt1.pred_taken", {31'd0, if_id_pred_taken}, 32'd1);
        updateBtb(32'h10, 32'h990, 0);
        fetchAt(32'h10);
        checkOutput("nt2.imemaddr", imemaddr, 32'h14);
        checkOutput("nt2.pred_taken", {31'd0, if_id_pred_taken}, 32'd0);
        checkOutput("nt2.pred_target", if_id_pred_target, 32'h14);
        // Saturate low, then two taken updates reach weakly taken with new target
        repeat (2) updateBtb(32'h10, 32'h990, 0);
        repeat (2) updateBtb(32'h10, 32'h80, 1);
        fetchAt(32'h10);
        checkOutput("satlo.imemaddr", imemaddr, 32'h80);
        checkOutput("satlo.pred_target", if_id_pred_target, 32'h80);

        // Aliasing: 0x50 shares the index of 0x10 with a different tag
        updateBtb(32'h50, 32'h60, 1);
        fetchAt(32'h10);
        checkOutput("alias.imemaddr", imemaddr, 32'h14);
        checkOutput("alias.pred_taken", {31'd0, if_id_pred_taken}, 32'd0);
        updateBtb(32'h90, 32'h70, 0);
        fetchAt(32'h50);
        checkOutput("alias50.imemaddr", imemaddr, 32'h60);

        // Read-before-write: lookup and not-taken update to 0x50 together
        clearInputs();
        mem_redirect = 1; mem_target = 32'h50;
        applyStimulus(1);
        clearInputs();
        pcen = 1; if_id_en = 1; ihit = 1; imemload = 32'hBB;
        upd_valid = 1; upd_pc = 32'h50; upd_target = 32'h990; upd_taken = 0;
        applyStimulus(1);
        clearInputs();
        checkOutput("rbw.imemaddr", imemaddr, 32'h60);
        checkOutput("rbw.pred_taken", {31'd0, if_id_pred_taken}, 32'd1);
        fetchAt(32'h50);
        checkOutput("rbw2.imemaddr", imemaddr, 32'h54);

        // Capture without ihit marks the latch invalid
        mem_redirect = 1; mem_target = 32'h100;
        applyStimulus(1);
        clearInputs();
        pcen = 1; if_id_en = 1; ihit = 0; imemload = 32'hCC;
        applyStimulus(1);
        clearInputs();
        checkOutput("noihit.if_id_valid", {31'd0, if_id_valid}, 32'd0);
        checkOutput("noihit.if_id_pc", if_id_pc, 32'h100);
        checkOutput("noihit.imemaddr", imemaddr, 32'h104);

        // PC+4 wraps
        fetchAt(32'hFFFF_FFFC);
        checkOutput("wrap.imemaddr", imemaddr, 32'h0);
        checkOutput("wrap.if_id_npc", if_id_npc, 32'h0);

        // Redirect ignores pcen = 0
        mem_redirect = 1; mem_target = 32'h200;
        applyStimulus(1);
        clearInputs();
        checkOutput("redir.imemaddr", imemaddr, 32'h200);

        // Halt freezes the PC and blocks later redirects
        halt = 1;
        applyStimulus(1);
        clearInputs();
        checkOutput("halt.imemREN", {31'd0, imemREN}, 32'd0);
        checkOutput("halt.imemaddr", imemaddr, 32'h200);
        mem_redirect = 1; mem_target = 32'h300; pcen = 1;
        applyStimulus(2);
        clearInputs();
        checkOutput("haltredir.imemaddr", imemaddr, 32'h200);
        updateBtb(32'h200, 32'h240, 1);

        // Reset beats a concurrent redirect and BTB update
        RST = 1; mem_redirect = 1; mem_target = 32'h300;
        upd_valid = 1; upd_pc = 32'h10; upd_target = 32'h44; upd_taken = 1;
        applyStimulus(1);
        RST = 0;
        clearInputs();
        checkOutput("rst2.imemaddr", imemaddr, 32'h0);
        checkOutput("rst2.imemREN", {31'd0, imemREN}, 32'd1);
        fetchAt(32'h10);
        checkOutput("rst2.fetch10", imemaddr, 32'h14);
        checkOutput("rst2.pred_taken", {31'd0, if_id_pred_taken}, 32'd0);

        applyStimulus(1);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
